cdb_arbiter: RTL

//  Shares the single common data bus (CDB) among NUM_REQ functional units. Each unit hands a

---
 rtl/cdb_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cdb_arbiter: round-robin sharing of the common data bus among NUM_REQ    |
// | units through one-entry holding slots.                 Rev 1.0            |
// +--------------------------------------------------------------------------+
module cdb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TAG_WIDTH  = 6
) (
   input  logic                             clk,
   input  logic                             n_rst,
   input  logic                             i_flush,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   output logic [NUM_REQ-1:0]               o_req_ready,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]     i_req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
   input  logic [NUM_REQ-1:0]               i_req_redirect,
   output logic                             o_cdb_en,
   output logic                             o_cdb_redirect,
   output logic [TAG_WIDTH-1:0]             o_cdb_tag,
   output logic [DATA_WIDTH-1:0]            o_cdb_data,
   output logic [ADDR_WIDTH-1:0]            o_cdb_addr
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    r_slot_valid;
   logic [NUM_REQ-1:0]    r_slot_redir;
   logic [TAG_WIDTH-1:0]  r_slot_tag  [NUM_REQ];
   logic [DATA_WIDTH-1:0] r_slot_data [NUM_REQ];
   logic [ADDR_WIDTH-1:0] r_slot_addr [NUM_REQ];
   logic [PTR_W-1:0]      r_rr_ptr;

   logic                  r_cdb_en;
   logic                  r_cdb_redirect;
   logic [TAG_WIDTH-1:0]  r_cdb_tag;
   logic [DATA_WIDTH-1:0] r_cdb_data;
   logic [ADDR_WIDTH-1:0] r_cdb_addr;

   logic [NUM_REQ-1:0]    w_grant;
   logic                  w_gnt_any;
   logic [PTR_W-1:0]      w_gnt_idx;
   logic [PTR_W-1:0]      w_idx;
   int                    w_scan;
   logic [NUM_REQ-1:0]    w_accept;

   // Scan slots starting at the round-robin pointer, wrapping at NUM_REQ
   always_comb begin
      w_grant   = '0;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_idx     = '0;
      w_scan    = 0;
      if (!i_flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_REQ) w_scan = w_scan - NUM_REQ;
            w_idx = PTR_W'(w_scan);
            if (!w_gnt_any && r_slot_valid[w_idx]) begin
               w_gnt_any        = 1'b1;
               w_gnt_idx        = w_idx;
               w_grant[w_idx]   = 1'b1;
            end
         end
      end
   end

   assign o_req_ready = {NUM_REQ{~i_flush}} & (~r_slot_valid | w_grant);
   assign w_accept    = i_req_valid & o_req_ready;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_slot_valid <= '0;
         r_slot_redir <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            r_slot_tag[k]  <= '0;
            r_slot_data[k] <= '0;
            r_slot_addr[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (i_flush) begin
               r_slot_valid[k] <= 1'b0;
            end else if (w_accept[k]) begin
               // A granted slot may refill on the edge it drains
               r_slot_valid[k] <= 1'b1;
               r_slot_redir[k] <= i_req_redirect[k];
               r_slot_tag[k]   <= i_req_tag[k*TAG_WIDTH +: TAG_WIDTH];
               r_slot_data[k]  <= i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
               r_slot_addr[k]  <= i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end else if (w_grant[k]) begin
               r_slot_valid[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_cdb_en       <= 1'b0;
         r_cdb_redirect <= 1'b0;
         r_cdb_tag      <= '0;
         r_cdb_data     <= '0;
         r_cdb_addr     <= '0;
         r_rr_ptr       <= '0;
      end else if (w_gnt_any) begin
         r_cdb_en       <= 1'b1;
         r_cdb_redirect <= r_slot_redir[w_gnt_idx];
         r_cdb_tag      <= r_slot_tag[w_gnt_idx];
         r_cdb_data     <= r_slot_data[w_gnt_idx];
         r_cdb_addr     <= r_slot_addr[w_gnt_idx];
         r_rr_ptr       <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
      end else begin
         r_cdb_en <= 1'b0;
         if (i_flush) r_rr_ptr <= '0;
      end
   end

   assign o_cdb_en       = r_cdb_en;
   assign o_cdb_redirect = r_cdb_redirect;
   assign o_cdb_tag      = r_cdb_tag;
   assign o_cdb_data     = r_cdb_data;
   assign o_cdb_addr     = r_cdb_addr;

endmodule
`default_nettype wire
